// File: rtl/note_game_pkg.sv
// Shared types and constants for the note game judgement path.
package note_game_pkg;

    localparam int LANES           = 5;
    localparam int DEF_PERFECT_PTS = 20;
    localparam int DEF_GOOD_PTS    = 10;
    localparam int SCORE_W         = 16;
    localparam int COMBO_W         = 8;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } lane_state_e;

    function automatic logic [3:0] popcount(input logic [LANES-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/note_judge_if.sv
// Per-tick note/key rows in, judgement pulses and running totals out.
interface note_judge_if #(
    parameter int LANES = note_game_pkg::LANES
);
    // No valid/ready: every clk_slow tick carries exactly one note row and one
    // key row, and every result field is valid on every tick (pulses are one tick).
    logic                               game_en;
    logic [LANES-1:0]                   note_in;
    logic [LANES-1:0]                   key_in;
    logic [LANES-1:0]                   hit_perfect;
    logic [LANES-1:0]                   hit_good;
    logic [LANES-1:0]                   miss;
    logic [note_game_pkg::SCORE_W-1:0]  score;
    logic [note_game_pkg::COMBO_W-1:0]  combo;
    logic [note_game_pkg::COMBO_W-1:0]  max_combo;
    logic [LANES-1:0]                   dbg_pend;

    modport master (
        output game_en, note_in, key_in,
        input  hit_perfect, hit_good, miss, score, combo, max_combo, dbg_pend
    );

    modport slave (
        input  game_en, note_in, key_in,
        output hit_perfect, hit_good, miss, score, combo, max_combo, dbg_pend
    );

endinterface

// File: rtl/note_lane_judge.sv
// One lane's timing window: classifies each arriving note as perfect, good or miss.
module note_lane_judge import note_game_pkg::*; #(
    parameter int WINDOW = 2
) (
    input  logic        clk_slow,
    input  logic        rst,
    input  logic        game_en,
    input  logic        note,
    input  logic        key,
    output logic        perfect_d,
    output logic        good_d,
    output logic        miss_d,
    output logic        perfect,
    output logic        good,
    output logic        miss,
    output lane_state_e state
);

    lane_state_e state_d;
    logic [2:0]  age, age_d;

    // Next-state judgement is also exported so the top can score in the same edge.
    always_comb begin
        perfect_d = 1'b0;
        good_d    = 1'b0;
        miss_d    = 1'b0;
        state_d   = state;
        age_d     = age;
        if (!game_en) begin
            state_d = IDLE;
            age_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (note) begin
                        if (key) begin
                            perfect_d = 1'b1;
                        end else if (WINDOW == 1) begin
                            miss_d = 1'b1;
                        end else begin
                            state_d = PEND;
                            age_d   = 3'd1;
                        end
                    end
                end
                PEND: begin
                    if (key) begin
                        // Key belongs to the old note; a coincident note opens a new window.
                        good_d = 1'b1;
                        if (note) begin
                            age_d = 3'd1;
                        end else begin
                            state_d = IDLE;
                            age_d   = '0;
                        end
                    end else if (note) begin
                        miss_d = 1'b1;
                        age_d  = 3'd1;
                    end else if (age == 3'(WINDOW - 1)) begin
                        miss_d  = 1'b1;
                        state_d = IDLE;
                        age_d   = '0;
                    end else begin
                        age_d = age + 3'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    age_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_slow) begin
        if (rst) begin
            state   <= IDLE;
            age     <= '0;
            perfect <= 1'b0;
            good    <= 1'b0;
            miss    <= 1'b0;
        end else begin
            state   <= state_d;
            age     <= age_d;
            perfect <= perfect_d;
            good    <= good_d;
            miss    <= miss_d;
        end
    end

endmodule

// File: rtl/note_judge.sv
// Hit-judgement stage: per-lane judges plus saturating score, combo and max combo.
module note_judge import note_game_pkg::*; #(
    parameter int WINDOW      = 2,
    parameter int PERFECT_PTS = DEF_PERFECT_PTS,
    parameter int GOOD_PTS    = DEF_GOOD_PTS
) (
    input  logic         clk_slow,
    input  logic         rst,
    note_judge_if.slave  bus
);

    logic [LANES-1:0]   perf_d, good_d, miss_d;
    logic [LANES-1:0]   perf_q, good_q, miss_q;
    logic [LANES-1:0]   pend;
    lane_state_e        lane_state [LANES];

    logic [SCORE_W-1:0] score_q, score_next;
    logic [COMBO_W-1:0] combo_q, combo_next, max_q;
    logic [18:0]        score_sum;
    logic [9:0]         combo_sum;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        note_lane_judge #(.WINDOW(WINDOW)) u_lane (
            .clk_slow  (clk_slow),
            .rst       (rst),
            .game_en   (bus.game_en),
            .note      (bus.note_in[i]),
            .key       (bus.key_in[i]),
            .perfect_d (perf_d[i]),
            .good_d    (good_d[i]),
            .miss_d    (miss_d[i]),
            .perfect   (perf_q[i]),
            .good      (good_q[i]),
            .miss      (miss_q[i]),
            .state     (lane_state[i])
        );
        assign pend[i] = (lane_state[i] == PEND);
    end

    // Points are never cancelled by misses; only the combo is.
    always_comb begin
        score_sum = 19'(score_q)
                  + 19'(PERFECT_PTS) * 19'(popcount(perf_d))
                  + 19'(GOOD_PTS) * 19'(popcount(good_d));
        combo_sum = 10'(combo_q) + 10'(popcount(perf_d | good_d));
        score_next = (score_sum > 19'h0FFFF) ? 16'hFFFF : score_sum[15:0];
        if (|miss_d) begin
            combo_next = '0;
        end else if (combo_sum > 10'd255) begin
            combo_next = 8'hFF;
        end else begin
            combo_next = combo_sum[7:0];
        end
    end

    always_ff @(posedge clk_slow) begin
        if (rst) begin
            score_q <= '0;
            combo_q <= '0;
            max_q   <= '0;
        end else begin
            score_q <= score_next;
            combo_q <= combo_next;
            max_q   <= (combo_next > max_q) ? combo_next : max_q;
        end
    end

    assign bus.hit_perfect = perf_q;
    assign bus.hit_good    = good_q;
    assign bus.miss        = miss_q;
    assign bus.score       = score_q;
    assign bus.combo       = combo_q;
    assign bus.max_combo   = max_q;
    assign bus.dbg_pend    = pend;

endmodule
